// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes,
// datapath mux selects and the control output bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_LW  = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_ctl_op;
        logic       retired;
    } ctl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control bus between the main control FSM and the datapath/memory.
// slave = controller side, master = datapath/memory side.
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       regs_equal;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_ctl_op;
    logic       retired;
    logic       illegal;

    modport slave (
        input  opcode, regs_equal, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctl_op, retired, illegal
    );

    modport master (
        output opcode, regs_equal, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctl_op, retired, illegal
    );
endinterface

// File: rtl/mc_ctl_decode.sv
// Purpose: combinational map from FSM state (+ mem_ready/regs_equal) to datapath enables.
// Latency: zero cycles. Backpressure: none; mem_ready only qualifies the request states.
module mc_ctl_decode
    import mc_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   regs_equal_i,
    output ctl_t   ctl_o
);

    always_comb begin
        ctl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctl_o.mem_read   = 1'b1;
                ctl_o.alu_src_b  = ALUB_FOUR;
                ctl_o.alu_ctl_op = 1'b1;
                ctl_o.ir_write   = mem_ready_i;
                ctl_o.pc_write   = mem_ready_i;
                ctl_o.pc_src     = PC_SRC_SEQ;
            end
            S_EXEC_R: begin
                ctl_o.alu_src_a  = 1'b1;
                ctl_o.alu_src_b  = ALUB_RT;
            end
            S_WB_R: begin
                ctl_o.reg_write  = 1'b1;
                ctl_o.reg_dst    = 1'b1;
                ctl_o.retired    = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                ctl_o.alu_src_a  = 1'b1;
                ctl_o.alu_src_b  = ALUB_IMM;
                ctl_o.alu_ctl_op = 1'b1;
            end
            S_WB_I: begin
                ctl_o.reg_write  = 1'b1;
                ctl_o.retired    = 1'b1;
            end
            S_MEM_RD: begin
                ctl_o.mem_read   = 1'b1;
                ctl_o.iord       = 1'b1;
            end
            S_WB_LW: begin
                ctl_o.reg_write  = 1'b1;
                ctl_o.mem_to_reg = 1'b1;
                ctl_o.retired    = 1'b1;
            end
            S_MEM_WR: begin
                // a store retires in the cycle memory accepts it
                ctl_o.mem_write  = 1'b1;
                ctl_o.iord       = 1'b1;
                ctl_o.retired    = mem_ready_i;
            end
            S_BRANCH: begin
                ctl_o.pc_src     = PC_SRC_BRANCH;
                ctl_o.pc_write   = regs_equal_i;
                ctl_o.retired    = 1'b1;
            end
            S_JUMP: begin
                ctl_o.pc_write   = 1'b1;
                ctl_o.pc_src     = PC_SRC_JUMP;
                ctl_o.retired    = 1'b1;
            end
            default: ctl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Purpose: multi-cycle MIPS main control FSM (fetch/decode/exec/mem/wb sequencing).
// Latency: outputs combinational from state; 2..5 cycles per instruction plus memory waits.
// Backpressure: FETCH/MEM_RD/MEM_WR hold their request until mem_ready; no timeout.
module mc_main_control
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mc_main_control_if.slave   bus
);

    state_e state_q, state_d;
    ctl_t   ctl;
    ctl_t   ctl_out;
    logic   illegal;

    mc_ctl_decode u_decode (
        .state_i      (state_q),
        .mem_ready_i  (bus.mem_ready),
        .regs_equal_i (bus.regs_equal),
        .ctl_o        (ctl)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_EXEC_I;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            // the IR is stable here, so opcode only picks load vs store
            S_ADDR:   state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (bus.mem_ready) state_d = S_WB_LW;
            S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl_out = rst ? '0 : ctl;
        illegal = !rst && (state_q == S_DECODE) && !op_supported(bus.opcode);
    end

    assign bus.pc_write   = ctl_out.pc_write;
    assign bus.pc_src     = ctl_out.pc_src;
    assign bus.ir_write   = ctl_out.ir_write;
    assign bus.iord       = ctl_out.iord;
    assign bus.mem_read   = ctl_out.mem_read;
    assign bus.mem_write  = ctl_out.mem_write;
    assign bus.reg_write  = ctl_out.reg_write;
    assign bus.reg_dst    = ctl_out.reg_dst;
    assign bus.mem_to_reg = ctl_out.mem_to_reg;
    assign bus.alu_src_a  = ctl_out.alu_src_a;
    assign bus.alu_src_b  = ctl_out.alu_src_b;
    assign bus.alu_ctl_op = ctl_out.alu_ctl_op;
    assign bus.retired    = ctl_out.retired;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: per-instruction cycle plans built from the
// instruction-class rules, compared cycle by cycle against the DUT outputs.
module tb_mc_main_control;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_ctl_op;
        logic       retired;
        logic       illegal;
    } vec_t;

    typedef struct packed {
        logic rdy;
        vec_t exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    cyc_t plan[$];

    mc_main_control_if bus ();

    mc_main_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    endfunction

    function automatic void add(input logic rdy, input vec_t e);
        cyc_t c;
        c.rdy = rdy;
        c.exp = e;
        plan.push_back(c);
    endfunction

    function automatic vec_t fetch_vec(input logic done);
        vec_t v = '0;
        v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.alu_ctl_op = 1'b1;
        v.ir_write = done; v.pc_write = done;
        return v;
    endfunction

    // Expected cycle-by-cycle behaviour of one whole instruction.
    // fw/mw: memory wait cycles in the fetch and data phases.
    function automatic void build(input logic [5:0] op, input int fw, input int mw, input logic eq);
        vec_t v;
        plan.delete();
        for (int i = 0; i < fw; i++) add(1'b0, fetch_vec(1'b0));
        add(1'b1, fetch_vec(1'b1));
        v = '0; v.illegal = !legal(op);
        add(1'($urandom), v);
        if (op == T_R) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b00;
            add(1'($urandom), v);
            v = '0; v.reg_write = 1'b1; v.reg_dst = 1'b1; v.retired = 1'b1;
            add(1'($urandom), v);
        end else if (op == T_ADDI || op == T_LW || op == T_SW) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctl_op = 1'b1;
            add(1'($urandom), v);
            if (op == T_ADDI) begin
                v = '0; v.reg_write = 1'b1; v.retired = 1'b1;
                add(1'($urandom), v);
            end else if (op == T_LW) begin
                v = '0; v.mem_read = 1'b1; v.iord = 1'b1;
                for (int i = 0; i <= mw; i++) add(i == mw, v);
                v = '0; v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.retired = 1'b1;
                add(1'($urandom), v);
            end else begin
                v = '0; v.mem_write = 1'b1; v.iord = 1'b1;
                for (int i = 0; i < mw; i++) add(1'b0, v);
                v.retired = 1'b1;
                add(1'b1, v);
            end
        end else if (op == T_BEQ) begin
            v = '0; v.pc_src = 2'b01; v.pc_write = eq; v.retired = 1'b1;
            add(1'($urandom), v);
        end else if (op == T_J) begin
            v = '0; v.pc_write = 1'b1; v.pc_src = 2'b10; v.retired = 1'b1;
            add(1'($urandom), v);
        end
    endfunction

    // One clock cycle: drive inputs after the rising edge, sample on the falling edge.
    task automatic step(input logic r, input logic rdy, output vec_t obs);
        rst = r;
        bus.mem_ready = rdy;
        @(negedge clk);
        obs.pc_write   = bus.pc_write;
        obs.pc_src     = bus.pc_src;
        obs.ir_write   = bus.ir_write;
        obs.iord       = bus.iord;
        obs.mem_read   = bus.mem_read;
        obs.mem_write  = bus.mem_write;
        obs.reg_write  = bus.reg_write;
        obs.reg_dst    = bus.reg_dst;
        obs.mem_to_reg = bus.mem_to_reg;
        obs.alu_src_a  = bus.alu_src_a;
        obs.alu_src_b  = bus.alu_src_b;
        obs.alu_ctl_op = bus.alu_ctl_op;
        obs.retired    = bus.retired;
        obs.illegal    = bus.illegal;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t obs;
        bus.opcode = T_SW; bus.regs_equal = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), obs);
            checks++;
            if (obs !== vec_t'(0)) begin
                errors++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, vec_t'(0));
            end
        end
        step(1'b0, 1'b0, obs);
        checks++;
        if (obs !== fetch_vec(1'b0)) begin
            errors++; $display("FAIL reset_release: got %b want %b", obs, fetch_vec(1'b0));
        end
    endtask

    task automatic test_lw_waits();
        vec_t obs;
        bus.opcode = T_LW; bus.regs_equal = 1'b0;
        build(T_LW, 2, 1, 1'b0);
        foreach (plan[i]) begin
            step(1'b0, plan[i].rdy, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL lw_waits cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
    endtask

    task automatic test_rtype();
        vec_t obs;
        bus.opcode = T_R;
        build(T_R, 0, 0, 1'b0);
        foreach (plan[i]) begin
            step(1'b0, 1'b1, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL rtype cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
    endtask

    task automatic test_beq();
        vec_t obs;
        bus.opcode = T_BEQ;
        for (int e = 1; e >= 0; e--) begin
            bus.regs_equal = 1'(e);
            build(T_BEQ, 0, 0, 1'(e));
            foreach (plan[i]) begin
                step(1'b0, plan[i].rdy, obs);
                checks++;
                if (obs !== plan[i].exp) begin
                    errors++; $display("FAIL beq_eq%0d cyc%0d: got %b want %b", e, i, obs, plan[i].exp);
                end
            end
        end
    endtask

    task automatic test_sw_stall();
        vec_t obs;
        bus.opcode = T_SW;
        build(T_SW, 0, 5, 1'b0);
        foreach (plan[i]) begin
            step(1'b0, plan[i].rdy, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL sw_stall cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t obs;
        bus.opcode = 6'b111111;
        build(6'b111111, 0, 0, 1'b0);
        build(T_J, 0, 0, 1'b0);
        begin
            cyc_t tmp[$];
            tmp = plan;
            build(6'b111111, 0, 0, 1'b0);
            // illegal returns straight to FETCH: follow with a full j
            foreach (tmp[i]) plan.push_back(tmp[i]);
        end
        foreach (plan[i]) begin
            if (i == 2) bus.opcode = T_J;
            step(1'b0, plan[i].rdy, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
    endtask

    task automatic test_reset_midway();
        vec_t obs;
        bus.opcode = T_SW;
        build(T_SW, 0, 10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, plan[i].rdy, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL midway_pre cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
        step(1'b1, 1'b1, obs);
        checks++;
        if (obs !== vec_t'(0)) begin
            errors++; $display("FAIL midway_rst: got %b want %b", obs, vec_t'(0));
        end
        step(1'b0, 1'b0, obs);
        checks++;
        if (obs !== fetch_vec(1'b0)) begin
            errors++; $display("FAIL midway_after: got %b want %b", obs, fetch_vec(1'b0));
        end
        bus.opcode = T_J;
        build(T_J, 0, 0, 1'b0);
        foreach (plan[i]) begin
            step(1'b0, plan[i].rdy, obs);
            checks++;
            if (obs !== plan[i].exp) begin
                errors++; $display("FAIL midway_j cyc%0d: got %b want %b", i, obs, plan[i].exp);
            end
        end
    endtask

    task automatic test_random();
        vec_t obs;
        logic [5:0] ops[6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        logic [5:0] op;
        logic eq;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end
            eq = 1'($urandom);
            bus.opcode = op;
            bus.regs_equal = eq;
            build(op, $urandom_range(0, 3), $urandom_range(0, 3), eq);
            foreach (plan[i]) begin
                step(1'b0, plan[i].rdy, obs);
                checks++;
                if (obs !== plan[i].exp) begin
                    errors++; $display("FAIL random n%0d op%b cyc%0d: got %b want %b", n, op, i, obs, plan[i].exp);
                end
            end
        end
    endtask

    initial begin
        bus.opcode = '0;
        bus.regs_equal = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lw_waits();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_illegal();
        test_reset_midway();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control FSM for the MIPS core. Decodes the instruction opcode, sequences the fetch, decode, execute, memory and writeback steps, and drives every datapath enable. It is the producer of `alu_ctl_op`, which the ALU-control decoder combines with `funct` to select the ALU operation. It also owns the memory-ready handshake and signals instruction retirement.

## Interface
Parameters:
- none; encodings live in the shared package.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instruction bits [31:26], taken from the instruction register
- `regs_equal`  in  1  result of the datapath rs==rt comparator
- `mem_ready`  in  1  memory has completed the current read or write in this cycle
- `pc_write`  out  1  load the PC
- `pc_src`  out  2  PC source: 00 = ALU result (PC+4), 01 = branch target, 10 = jump target
- `ir_write`  out  1  load the instruction register
- `iord`  out  1  memory address: 0 = PC, 1 = ALU result register
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `reg_write`  out  1  register-file write enable
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  writeback source: 0 = ALU result register, 1 = memory data register
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate
- `alu_ctl_op`  out  1  0 = use `funct`, 1 = force add
- `retired`  out  1  one-cycle pulse when an instruction completes
- `illegal`  out  1  one-cycle pulse on an unsupported opcode

## Operation
Supported opcodes:
- 000000 R-type
- 100011 lw
- 101011 sw
- 000100 beq
- 000010 j
- 001000 addi

States and the outputs asserted in each; any output not listed is 0:
- FETCH: `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctl_op`=1.
  - While `mem_ready`=0: stay in FETCH.
  - In the cycle `mem_ready`=1: assert `ir_write`, `pc_write`, `pc_src`=00, then go to DECODE.
- DECODE: no enables asserted.
  - Next state by opcode: R-type to EXEC_R, lw/sw to ADDR, beq to BRANCH, j to JUMP, addi to EXEC_I.
  - Any other opcode: pulse `illegal`, go to FETCH, no retire.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_ctl_op`=0, then go to WB_R.
- WB_R: `reg_write`, `reg_dst`=1, `mem_to_reg`=0, `retired`, then go to FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_ctl_op`=1, then go to WB_I.
- WB_I: `reg_write`, `reg_dst`=0, `mem_to_reg`=0, `retired`, then go to FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_ctl_op`=1. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`, `iord`=1.
  - Hold until `mem_ready`=1, then go to WB_LW.
- WB_LW: `reg_write`, `reg_dst`=0, `mem_to_reg`=1, `retired`, then go to FETCH.
- MEM_WR: `mem_write`, `iord`=1.
  - Hold until `mem_ready`=1; in that cycle pulse `retired` and go to FETCH.
- BRANCH: `pc_src`=01, `pc_write`=`regs_equal`, `retired`, then go to FETCH.
- JUMP: `pc_write`, `pc_src`=10, `retired`, then go to FETCH.

Opcode decode rules:
- The opcode is decoded in DECODE only. The IR holds the instruction stable after FETCH, so later states re-read `opcode` solely to choose between MEM_RD and MEM_WR.
- R-type nop (funct 000000) follows the normal R path; the write targets $0.

## Timing
Reset:
- `rst` high at a clock edge puts the FSM in FETCH.
- While `rst` is high, every output is forced to 0, including `mem_read`, `retired` and `illegal`.
- On the first cycle after `rst` falls, the FETCH outputs are driven.
- Reset in the middle of a sequence (for example during MEM_WR waiting) aborts it: no `retired` pulse, and the write request drops in the reset cycle.

Output timing:
- Outputs are decoded combinationally from the current state.
- `ir_write`, `pc_write` (in FETCH), `pc_write` (in BRANCH) and `retired` (in MEM_WR) also depend on the current-cycle input (`mem_ready` or `regs_equal`).

Minimum cycles per instruction, with zero memory wait:
- j: 3
- beq: 3
- sw: 4
- R-type: 4
- addi: 4
- lw: 5
- illegal opcode: 2

Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle. There is no timeout.

Handshake rules:
- `mem_read` and `mem_write` are never asserted together.
- A request stays asserted, with its address select unchanged, until `mem_ready` is seen.
- `mem_ready` in any state that has no request is ignored.

## Structure
- Package `mc_pkg` holds:
  - the state enum (4-bit, 12 states)
  - opcode constants
  - `pc_src` and `alu_src_b` encodings
- One natural sub-module: `mc_ctl_decode`, a pure combinational map from (state, `mem_ready`, `regs_equal`) to the output bundle.
- The top module contains the state register and the next-state logic.

## Test plan
- Reset, then lw (100011) with 2 FETCH wait cycles and 1 MEM_RD wait cycle: sequence FETCH×3, DECODE, ADDR, MEM_RD×2, WB_LW. In WB_LW: `reg_write`=1, `mem_to_reg`=1, `retired` pulses once.
- R-type add with `mem_ready` always 1: `retired` on cycle 4; `alu_ctl_op`=0 only in EXEC_R; `reg_dst`=1 in WB_R.
- beq with `regs_equal`=1, then with `regs_equal`=0: `pc_write`=1 with `pc_src`=01 in the first case, `pc_write`=0 in the second; `retired` in both; 3 cycles each.
- sw with `mem_ready` held low for 5 cycles: `mem_write`=1 and `iord`=1 stable for all 6 cycles, `mem_read`=0 throughout, `retired` in the `mem_ready` cycle.
- Opcode 111111: `illegal` pulses in DECODE, no `reg_write`/`mem_write`/`retired`, returns to FETCH on the next cycle.
- `rst` asserted during MEM_WR wait: all outputs 0 in the reset cycle; FETCH outputs (`mem_read`=1, `alu_src_b`=01) on the following cycle; no `retired` pulse.
